instruction_loader: RTL and testbench

- Writer side of the instruction memory interface.
- Takes a byte stream through a valid/ready handshake and assembles it little-endian into 32-bit instruction words.
- Writes each word to consecutive word-aligned addresses in instruction memory, so the fetch/decode path can later read the program.
- Used to load test programs at runtime instead of only from the .mif image; reports a running XOR checksum and a completion pulse.

---
 rtl/instruction_loader.sv | 137 +++++++++++++
 tb/tb_instruction_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Instruction loader: assembles a little-endian byte stream into 32-bit words
// and writes them to consecutive word addresses of instruction memory.
module instruction_loader #(
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [31:0]            base_addr,
   input  logic [COUNT_WIDTH-1:0] word_count,
   input  logic                   byte_valid,
   input  logic [7:0]             byte_data,
   output logic                   byte_ready,
   output logic                   mem_write,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_data,
   input  logic                   mem_ready,
   output logic                   busy,
   output logic                   done,
   output logic [31:0]            checksum,
   output logic [COUNT_WIDTH-1:0] words_written
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_byte_idx;
   logic [COUNT_WIDTH-1:0] r_remaining;
   logic                   r_byte_ready;
   logic                   r_mem_write;
   logic [ADDR_W-1:0]      r_mem_addr;
   logic [DATA_W-1:0]      r_mem_data;
   logic                   r_busy;
   logic                   r_done;
   logic [DATA_W-1:0]      r_checksum;
   logic [COUNT_WIDTH-1:0] r_words_written;

   // Load sequencer: state, handshake flags and datapath registers move together
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_byte_idx      <= '0;
         r_remaining     <= '0;
         r_byte_ready    <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_data      <= '0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_checksum      <= '0;
         r_words_written <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_checksum      <= '0;
                  r_words_written <= '0;
                  if (word_count != '0) begin
                     // Low address bits are dropped so writes stay word aligned
                     r_mem_addr   <= base_addr & ~ADDR_W'(3);
                     r_remaining  <= word_count;
                     r_byte_idx   <= '0;
                     r_byte_ready <= 1'b1;
                     r_busy       <= 1'b1;
                     r_state      <= S_COLLECT;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end

            S_COLLECT: begin
               if (byte_valid) begin
                  case (r_byte_idx)
                     2'd0:    r_mem_data[7:0]   <= byte_data;
                     2'd1:    r_mem_data[15:8]  <= byte_data;
                     2'd2:    r_mem_data[23:16] <= byte_data;
                     default: r_mem_data[31:24] <= byte_data;
                  endcase
                  r_byte_idx <= r_byte_idx + IDX_W'(1);
                  if (r_byte_idx == IDX_W'(3)) begin
                     r_byte_ready <= 1'b0;
                     r_mem_write  <= 1'b1;
                     r_state      <= S_WRITE;
                  end
               end
            end

            S_WRITE: begin
               if (mem_ready) begin
                  r_mem_write     <= 1'b0;
                  r_checksum      <= r_checksum ^ r_mem_data;
                  r_mem_addr      <= r_mem_addr + ADDR_W'(4);
                  r_words_written <= r_words_written + COUNT_WIDTH'(1);
                  r_remaining     <= r_remaining - COUNT_WIDTH'(1);
                  if (r_remaining == COUNT_WIDTH'(1)) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_byte_idx   <= '0;
                     r_byte_ready <= 1'b1;
                     r_state      <= S_COLLECT;
                  end
               end
            end

            default: begin
               // DONE lasts one cycle; results hold until the next start
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign byte_ready    = r_byte_ready;
   assign mem_write     = r_mem_write;
   assign mem_addr      = r_mem_addr;
   assign mem_data      = r_mem_data;
   assign busy          = r_busy;
   assign done          = r_done;
   assign checksum      = r_checksum;
   assign words_written = r_words_written;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
module tb_instruction_loader;

   localparam int unsigned CW = 16;

   logic          clock;
   logic          reset;
   logic          start;
   logic [31:0]   base_addr;
   logic [CW-1:0] word_count;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          mem_write;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_data;
   logic          mem_ready;
   logic          busy;
   logic          done;
   logic [31:0]   checksum;
   logic [CW-1:0] words_written;

   int n_total;
   int n_bad;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] wv[0:3];

   instruction_loader #(.COUNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_ready(mem_ready), .busy(busy), .done(done),
      .checksum(checksum), .words_written(words_written)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Record every accepted memory write; a write must never coincide with byte_ready
   always @(posedge clock) begin
      if (reset && mem_write) begin
         check("no_overlap", 32'(byte_ready), 32'd0);
         if (mem_ready) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_wr"},    32'(mem_write),  32'd0);
      check({tag, "_addr"},  mem_addr,        32'd0);
      check({tag, "_data"},  mem_data,        32'd0);
      check({tag, "_busy"},  32'(busy),       32'd0);
      check({tag, "_done"},  32'(done),       32'd0);
      check({tag, "_csum"},  checksum,        32'd0);
      check({tag, "_words"}, 32'(words_written), 32'd0);
   endtask

   // Run an n-word load of wv[] with optional byte gaps, one write stall,
   // and an optional start pulse during the first word
   task automatic run_load(input logic [31:0] base, input int n, input bit gap,
                           input int stall_word, input int stall_cycles,
                           input bit busy_start);
      logic [31:0] addr_exp;
      logic [31:0] csum_exp;
      logic [31:0] w;
      int          cyc;
      int          cyc_exp;
      addr_exp = base & 32'hFFFF_FFFC;
      csum_exp = 32'd0;
      cyc      = 0;
      cyc_exp  = 5 * n + 1;
      wr_addr_q.delete();
      wr_data_q.delete();
      mem_ready  = 1'b1;
      start      = 1'b1;
      base_addr  = base;
      word_count = CW'(n);
      tick(); cyc++;
      start = 1'b0;
      check("ld_busy", 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         w = wv[i];
         for (int k = 0; k < 4; k++) begin
            if (gap) begin
               byte_valid = 1'b0;
               tick(); cyc++; cyc_exp++;
            end
            byte_valid = 1'b1;
            byte_data  = w[8*k +: 8];
            if (busy_start && i == 0 && k == 1) begin
               start      = 1'b1;
               base_addr  = 32'h0000_0500;
               word_count = CW'(7);
            end
            tick(); cyc++;
            start = 1'b0;
         end
         byte_valid = 1'b0;
         check("ld_wr",   32'(mem_write), 32'd1);
         check("ld_addr", mem_addr, addr_exp);
         check("ld_data", mem_data, w);
         if (i == stall_word) begin
            mem_ready = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               tick(); cyc++; cyc_exp++;
               check("stall_wr",   32'(mem_write), 32'd1);
               check("stall_addr", mem_addr, addr_exp);
               check("stall_data", mem_data, w);
            end
            mem_ready = 1'b1;
         end
         tick(); cyc++;
         csum_exp = csum_exp ^ w;
         addr_exp = addr_exp + 32'd4;
      end
      check("ld_done",  32'(done), 32'd1);
      check("ld_cyc",   32'(cyc), 32'(cyc_exp));
      check("ld_busy0", 32'(busy), 32'd0);
      check("ld_csum",  checksum, csum_exp);
      check("ld_words", 32'(words_written), 32'(n));
      tick();
      check("ld_pulse", 32'(done), 32'd0);
      check("ld_nwr",   32'(wr_addr_q.size()), 32'(n));
      addr_exp = base & 32'hFFFF_FFFC;
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
         check("log_addr", wr_addr_q[i], addr_exp);
         check("log_data", wr_data_q[i], wv[i]);
         addr_exp = addr_exp + 32'd4;
      end
   endtask

   initial begin
      n_total    = 0;
      n_bad      = 0;
      reset      = 1'b0;
      start      = 1'b0;
      base_addr  = 32'd0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      mem_ready  = 1'b0;
      tick(); tick();
      check_all_zero("rst");
      reset = 1'b1;
      tick();

      // Single word
      wv[0] = 32'h0050_0093;
      run_load(32'h0000_0100, 1, 1'b0, -1, 0, 1'b0);
      check("sw_addr_hold", mem_addr, 32'h0000_0104);
      check("sw_data_hold", mem_data, 32'h0050_0093);

      // Three words, byte gaps and a 3-cycle stall on the second write
      wv[0] = 32'h1122_3344;
      wv[1] = 32'hDEAD_BEEF;
      wv[2] = 32'h0BAD_F00D;
      run_load(32'h0000_0003, 3, 1'b1, 1, 3, 1'b0);
      check("three_csum", checksum, 32'h1122_3344 ^ 32'hDEAD_BEEF ^ 32'h0BAD_F00D);

      // Zero count clears checksum and finishes on the next cycle
      wr_addr_q.delete();
      start      = 1'b1;
      word_count = '0;
      tick();
      start = 1'b0;
      check("zc_done",  32'(done), 32'd1);
      check("zc_busy",  32'(busy), 32'd0);
      check("zc_wr",    32'(mem_write), 32'd0);
      check("zc_csum",  checksum, 32'd0);
      check("zc_words", 32'(words_written), 32'd0);
      tick();
      check("zc_pulse", 32'(done), 32'd0);
      check("zc_nwr",   32'(wr_addr_q.size()), 32'd0);

      // Address wrap
      wv[0] = 32'hA5A5_0001;
      wv[1] = 32'h5A5A_0002;
      run_load(32'hFFFF_FFFC, 2, 1'b0, -1, 0, 1'b0);
      check("wrap_end", mem_addr, 32'h0000_0004);

      // Start while busy is ignored
      wv[0] = 32'h0102_0304;
      wv[1] = 32'h0506_0708;
      run_load(32'h0000_0200, 2, 1'b0, -1, 0, 1'b1);

      // Reset mid-load: 6 bytes of a 2-word load, then asynchronous reset
      wr_addr_q.delete();
      mem_ready  = 1'b1;
      start      = 1'b1;
      base_addr  = 32'h0;
      word_count = CW'(2);
      tick();
      start      = 1'b0;
      byte_valid = 1'b1;
      for (int t = 0; t < 7; t++) begin
         byte_data = 8'(8'h10 + t);
         tick();
      end
      byte_valid = 1'b0;
      check("mid_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check_all_zero("mid");
      tick();
      reset = 1'b1;
      check("mid_nwr", 32'(wr_addr_q.size()), 32'd1);
      tick();
      wv[0] = 32'hCAFE_F00D;
      run_load(32'h0000_0040, 1, 1'b0, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
